multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences a multi-cycle MIPS datapath: shared PC, IR, register file, ALU and one unified instruction/data memory.
- Successor to the single-cycle combinational control; the datapath registers are steered by this block's per-state strobes.
- Supports R-type, lw, sw, beq, bne, j and addi.
- Memory accesses use a ready handshake so a slow memory can stall the sequence.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26], taken from the IR.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero=1 (beq).
- PCWriteCondNe  out  1  PC load if ALU zero=0 (bne).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
- RegDst  out  1  write register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12.
- Outputs are decoded from state only. Every strobe not listed for a state is 0; every mux select not listed is 0.
- Reset: state=FETCH, retired=0. Reset has priority over everything, including mid-wait in any state.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle where mem_ready=1; that cycle moves to DECODE.
  - While mem_ready=0, stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target).
  - Next state by opcode: 0x00→R_EXEC, 0x23/0x2B→MEM_ADDR, 0x04/0x05→BRANCH, 0x02→JUMP, 0x08→I_EXEC.
  - Any other opcode: see Optional Feature.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw→MEM_READ, sw→MEM_WRITE. The opcode input is held stable by the IR.
- MEM_READ: MemRead=1, IorD=1. Wait for mem_ready=1, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1 held throughout the wait. On mem_ready=1 go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWriteCond=1 if opcode=0x04; PCWriteCondNe=1 if opcode=0x05. Never both.
  - Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- retired counter:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. A taken or untaken branch counts as retired.
  - Wraps modulo 2^CNT_W.
  - Does not increment on the reset cycle or on an illegal-opcode return.
- Latency in cycles with mem_ready tied high: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4. Each memory wait cycle adds 1.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE moves to HALT.
  - HALT drives all strobes 0 and holds until reset.
  - state output reads 12.
- Undefined:
  - An unsupported opcode in DECODE returns to FETCH, behaving as a 2-cycle NOP with retired unchanged.
  - HALT is unreachable.

Test Plan:
- reset=1 for 2 cycles, then release with mem_ready=1 and opcode=0x00 → state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in R_WB; retired=1 after 4 cycles.
- lw (0x23) with mem_ready low for 3 cycles in MEM_READ → MemRead=1 and IorD=1 held all 3 wait cycles, MEM_WB entered on the 4th; total latency 8; retired increments once.
- beq (0x04) then bne (0x05) → BRANCH asserts PCWriteCond only for beq and PCWriteCondNe only for bne; PCSource=01; 3 cycles each.
- sw (0x2B) → MemWrite=1 only in MEM_WRITE; RegWrite never asserted; retired+1.
- reset asserted during FETCH wait (mem_ready=0) → next cycle state=0, retired=0, no IRWrite pulse.
- opcode=0x3F with the macro defined → state=12, all strobes 0 for 10+ cycles. Without the macro → back to FETCH after DECODE, retired unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath (R, lw, sw, beq, bne, j, addi).
// Ports: clk, reset (sync, active-high), opcode, mem_ready in; datapath strobes,
// mux selects, debug state and retired-instruction counter out.
// Build option: define MULTICYCLE_ILLEGAL_TRAP_EN to trap unsupported opcodes in HALT.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_d = S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_I_EXEC;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:       state_d = S_HALT;
`else
                    // Unsupported opcode is dropped as a NOP, not retired.
                    default:       state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    begin state_d = S_FETCH; retire = 1'b1; end
            S_MEM_WRITE: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      begin state_d = S_FETCH; retire = 1'b1; end
            S_BRANCH:    begin state_d = S_FETCH; retire = 1'b1; end
            S_JUMP:      begin state_d = S_FETCH; retire = 1'b1; end
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      begin state_d = S_FETCH; retire = 1'b1; end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC only latch once the fetch actually completes.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:    ALUSrcB = 2'b11;
            S_MEM_ADDR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEM_READ:  begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEM_WB:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            S_MEM_WRITE: begin MemWrite = 1'b1; IorD = 1'b1; end
            S_R_EXEC:    begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_R_WB:      begin RegWrite = 1'b1; RegDst = 1'b1; end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                PCWriteCond   = (opcode == OP_BEQ);
                PCWriteCondNe = (opcode == OP_BNE);
            end
            S_JUMP:      begin PCWrite = 1'b1; PCSource = 2'b10; end
            S_I_EXEC:    begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_I_WB:      RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model predicts the
// per-cycle state, control word and retired count; a negedge monitor checks them.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] retired;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic [5:0]  op;
        logic [31:0] ret;
    } rec_t;

    rec_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   model_ret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h05 || op == 6'h02 || op == 6'h08;
    endfunction

    // Control word {PCWrite,PCWriteCond,PCWriteCondNe,IorD,MemRead,MemWrite,
    // IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [16:0] ctrl(input int st, input logic rdy, input logic [5:0] op);
        logic pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, aop, ps;
        {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 0; aop = 0; ps = 0;
        if (st == 0)  begin mr = 1; sb = 1; irw = rdy; pcw = rdy; end
        if (st == 1)  sb = 3;
        if (st == 2)  begin sa = 1; sb = 2; end
        if (st == 3)  begin mr = 1; iord = 1; end
        if (st == 4)  begin rw = 1; m2r = 1; end
        if (st == 5)  begin mw = 1; iord = 1; end
        if (st == 6)  begin sa = 1; aop = 2; end
        if (st == 7)  begin rw = 1; rd = 1; end
        if (st == 8)  begin sa = 1; aop = 1; ps = 1; pcc = (op == 6'h04); pcn = (op == 6'h05); end
        if (st == 9)  begin pcw = 1; ps = 2; end
        if (st == 10) begin sa = 1; sb = 2; end
        if (st == 11) rw = 1;
        return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (sbq.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                rec_t r;
                r = sbq.pop_front();
                check("state", {28'd0, state}, {28'd0, r.st});
                check("ctrl", {15'd0, PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead,
                               MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                               ALUSrcB, ALUOp, PCSource},
                      {15'd0, ctrl(int'(r.st), r.rdy, r.op)});
                check("retired", retired, r.ret);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st);
        rec_t e;
        reset = r; opcode = op; mem_ready = rdy;
        if (!r) begin
            e.st = st; e.rdy = rdy; e.op = op; e.ret = model_ret;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 6'($urandom), 1'($urandom), 4'd0);
        model_ret = 0;
    endtask

    // Expand one instruction into its cycle-by-cycle state walk and drive it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mwt, input int abort_at);
        logic [3:0] sq[$];
        logic       rq[$];
        bit         trap = 0;
        int         n;
        for (int i = 0; i < fw; i++) begin sq.push_back(0); rq.push_back(0); end
        sq.push_back(0); rq.push_back(1);
        sq.push_back(1); rq.push_back(1'($urandom));
        if (op == 6'h00) begin sq.push_back(6); sq.push_back(7); end
        else if (op == 6'h23) begin
            sq.push_back(2);
            for (int i = 0; i < mwt; i++) sq.push_back(3);
            sq.push_back(3); sq.push_back(4);
        end else if (op == 6'h2B) begin
            sq.push_back(2);
            for (int i = 0; i < mwt; i++) sq.push_back(5);
            sq.push_back(5);
        end else if (op == 6'h04 || op == 6'h05) sq.push_back(8);
        else if (op == 6'h02) sq.push_back(9);
        else if (op == 6'h08) begin sq.push_back(10); sq.push_back(11); end
        else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            trap = 1;
            repeat (12) sq.push_back(12);
`endif
        end
        // mem_ready per remaining cycle: waits low then completion high; others random
        n = rq.size();
        for (int i = n; i < sq.size(); i++) begin
            if ((sq[i] == 3 || sq[i] == 5))
                rq.push_back((i + 1 < sq.size() && sq[i+1] == sq[i]) ? 1'b0 : 1'b1);
            else
                rq.push_back(1'($urandom));
        end
        for (int i = 0; i < sq.size(); i++) begin
            if (i == abort_at) begin
                do_reset(1 + int'($urandom_range(0, 1)));
                return;
            end
            step(1'b0, (sq[i] == 0) ? 6'($urandom) : op, rq[i], sq[i]);
        end
        if (trap) do_reset(2);
        else if (is_legal(op)) model_ret++;
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        @(posedge clk); #1;
        do_reset(2);
        run_instr(6'h00, 0, 0, -1);
        run_instr(6'h23, 0, 3, -1);
        run_instr(6'h04, 0, 0, -1);
        run_instr(6'h05, 0, 0, -1);
        run_instr(6'h2B, 0, 0, -1);
        run_instr(6'h08, 0, 0, -1);
        run_instr(6'h02, 0, 0, -1);
        run_instr(6'h00, 3, 0, 2);
        run_instr(6'h00, 0, 0, -1);
        run_instr(6'h3F, 0, 0, -1);
        run_instr(6'h00, 1, 0, -1);
        for (int k = 0; k < 300; k++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 7) op = ops[sel];
            else begin
                do op = 6'($urandom); while (is_legal(op));
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
        end
        step(1'b1, 6'h00, 1'b0, 4'd0);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
